hazard_ctrl: RTL

- Pipeline control unit for the 5-stage RV32I core.
- Drives stall, hold and flush into the PC, IF/ID and ID/EX pipeline registers.
- Selects EX-stage operand forwarding from MEM or WB.
- Sequences multi-bubble load-use stalls and whole-pipe freezes on data-memory wait, and counts stall and flush events for performance monitoring.

---
 rtl/hazard_ctrl_pkg.sv | 19 +
 rtl/hazard_ctrl_fwd_unit.sv | 30 +++
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control definitions for the 5-stage RV32I core.
// Holds the forwarding-select encodings, the hazard FSM state encoding and
// the register-index width used by the hazard controller and its helpers.
package hazard_ctrl_pkg;

  localparam int REG_W = 5;

  // Forwarding mux select encodings for EX operands.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FREEZE   = 2'd2
  } state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Combinational forwarding compare for one source operand.
// Ports:
//   rs_i        source register index being read
//   rd_mem_i    destination index of the MEM-stage instruction
//   regw_mem_i  MEM-stage instruction writes the register file
//   rd_wb_i     destination index of the WB-stage instruction
//   regw_wb_i   WB-stage instruction writes the register file
//   sel_o       FWD_MEM, FWD_WB or FWD_RF (MEM has priority as the younger result)
module hazard_ctrl_fwd_unit
  import hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rd_mem_i,
  input  logic             regw_mem_i,
  input  logic [REG_W-1:0] rd_wb_i,
  input  logic             regw_wb_i,
  output logic [1:0]       sel_o
);

  // x0 is hardwired to zero, so a write to it is never forwarded.
  always_comb begin
    sel_o = FWD_RF;
    if (regw_mem_i && (rd_mem_i != '0) && (rd_mem_i == rs_i)) begin
      sel_o = FWD_MEM;
    end else if (regw_wb_i && (rd_wb_i != '0) && (rd_wb_i == rs_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/hold/flush for PC, IF/ID and ID/EX,
// EX operand forwarding, multi-bubble load-use stalls, data-memory freeze,
// and saturating stall/flush event counters.
// Ports:
//   clk, reset (async, active low)
//   rs1_d/rs2_d/use_rs1_d/use_rs2_d   decode-stage source usage
//   rs1_ex/rs2_ex/rd_ex/load_ex       execute-stage operands and load flag
//   rd_mem/RegW_en_mem, rd_wb/RegW_en_wb  younger writers for forwarding
//   PC_sel_ex  taken redirect from EX;  mem_busy  freeze whole pipe
//   stall_f/stall_d/hold_e/flush_d/flush_e  pipeline register controls
//   fwd_a_sel/fwd_b_sel  EX operand forwarding selects
//   stall_cnt/flush_cnt  saturating event counters
//   dbg_state  current FSM state
// Handshake: none; all control is same-cycle combinational from state and inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic             use_rs1_d,
  input  logic             use_rs2_d,
  input  logic [REG_W-1:0] rs1_ex,
  input  logic [REG_W-1:0] rs2_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             load_ex,
  input  logic [REG_W-1:0] rd_mem,
  input  logic             RegW_en_mem,
  input  logic [REG_W-1:0] rd_wb,
  input  logic             RegW_en_wb,
  input  logic             PC_sel_ex,
  input  logic             mem_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             hold_e,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       dbg_state
);

  localparam logic [2:0]       LB_M1   = 3'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d, ret_state_q, ret_state_d, eff_state;
  logic [2:0]       cnt_q, cnt_d, ret_cnt_q, ret_cnt_d, eff_cnt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic             stall_c, hold_c, flush_d_c, flush_e_c;
  logic             hazard_lu;

  hazard_ctrl_fwd_unit u_fwd_a (
    .rs_i(rs1_ex), .rd_mem_i(rd_mem), .regw_mem_i(RegW_en_mem),
    .rd_wb_i(rd_wb), .regw_wb_i(RegW_en_wb), .sel_o(fwd_a_sel)
  );

  hazard_ctrl_fwd_unit u_fwd_b (
    .rs_i(rs2_ex), .rd_mem_i(rd_mem), .regw_mem_i(RegW_en_mem),
    .rd_wb_i(rd_wb), .regw_wb_i(RegW_en_wb), .sel_o(fwd_b_sel)
  );

  assign hazard_lu = load_ex && (rd_ex != '0) &&
                     ((use_rs1_d && (rs1_d == rd_ex)) || (use_rs2_d && (rs2_d == rd_ex)));

  always_comb begin
    // Leaving FREEZE acts in the same cycle as the restored state.
    eff_state = state_q;
    eff_cnt   = cnt_q;
    if ((state_q == ST_FREEZE) && !mem_busy) begin
      eff_state = ret_state_q;
      eff_cnt   = ret_cnt_q;
    end
    state_d     = eff_state;
    cnt_d       = eff_cnt;
    ret_state_d = ret_state_q;
    ret_cnt_d   = ret_cnt_q;
    stall_c     = 1'b0;
    hold_c      = 1'b0;
    flush_d_c   = 1'b0;
    flush_e_c   = 1'b0;

    if (mem_busy) begin
      stall_c = 1'b1;
      hold_c  = 1'b1;
      // Capture the return point only on entry; later busy cycles keep it.
      if (state_q != ST_FREEZE) begin
        ret_state_d = state_q;
        ret_cnt_d   = cnt_q;
      end
      state_d = ST_FREEZE;
      cnt_d   = cnt_q;
    end else if (PC_sel_ex) begin
      // Redirect kills the stalled decode instruction, so the stall is moot.
      flush_d_c = 1'b1;
      flush_e_c = 1'b1;
      state_d   = ST_RUN;
      cnt_d     = '0;
    end else begin
      case (eff_state)
        ST_LU_STALL: begin
          stall_c   = 1'b1;
          flush_e_c = 1'b1;
          if (eff_cnt == 3'd1) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = eff_cnt - 3'd1;
          end
        end
        default: begin
          if (hazard_lu) begin
            stall_c   = 1'b1;
            flush_e_c = 1'b1;
            if (LOAD_BUBBLES > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LB_M1;
            end
          end
        end
      endcase
    end
  end

  // Reset forces the controls low combinationally, not just at the next edge.
  assign stall_f = reset & stall_c;
  assign stall_d = reset & stall_c;
  assign hold_e  = reset & hold_c;
  assign flush_d = reset & flush_d_c;
  assign flush_e = reset & flush_e_c;

  assign stall_cnt_d = (stall_f && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
  assign flush_cnt_d = (flush_d && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      ret_state_q <= ST_RUN;
      ret_cnt_q   <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_state_q <= ret_state_d;
      ret_cnt_q   <= ret_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule
